// File: rtl/axi_pkg.sv
// axi_pkg: AXI4-Lite response/protection constants and the RAM slave FSM state types.
package axi_pkg;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam int AXI_PROT_NS_BIT   = 1;
    localparam int AXI_PROT_INSN_BIT = 2;

    typedef enum logic [2:0] {W_IDLE, W_GOT_AW, W_GOT_W, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} r_state_t;

    function automatic logic [1:0] axi_resp(input logic err);
        return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    endfunction
endpackage

// File: rtl/axilite_ram_sp.sv
// axilite_ram_sp: single-port DEPTH x 32 RAM, byte-enable writes, 1-cycle synchronous read, no reset.
module axilite_ram_sp #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] addr,
    input  logic [3:0]       be,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/axilite_ram_slave.sv
// axilite_ram_slave: AXI4-Lite target over a byte-writable single-port RAM,
// one outstanding write and one outstanding read, range and NS-only protection checks.
module axilite_ram_slave
    import axi_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter int                DATA_W  = 32,
    parameter int                DEPTH   = 1024,
    parameter logic [ADDR_W-1:0] BASE    = '0,
    parameter bit                NS_ONLY = 1'b0
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [2:0]        s_axi_awprot,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [DATA_W-1:0] s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [2:0]        s_axi_arprot,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready
);
    localparam int                IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH * 4);

    w_state_t          w_state, w_next;
    r_state_t          r_state, r_next;
    logic [ADDR_W-1:0] aw_off, ar_off;
    logic              aw_err, ar_err, aw_hs, w_hs, ar_hs;
    logic [IDX_W-1:0]  w_idx, r_idx, ram_addr;
    logic              w_err, r_err, commit, rd_go;
    logic [DATA_W-1:0] w_data, ram_q;
    logic [3:0]        w_strb;
    logic [1:0]        w_resp;
    logic              unused_prot;

    // Subtracting BASE first makes addresses below BASE wrap high and fail the range test.
    assign aw_off = s_axi_awaddr - BASE;
    assign ar_off = s_axi_araddr - BASE;
    assign aw_err = aw_off >= SPAN || (NS_ONLY && !s_axi_awprot[AXI_PROT_NS_BIT]);
    assign ar_err = ar_off >= SPAN || (NS_ONLY && !s_axi_arprot[AXI_PROT_NS_BIT]);
    assign unused_prot = ^{s_axi_awprot[0], s_axi_awprot[AXI_PROT_INSN_BIT],
                           s_axi_arprot[0], s_axi_arprot[AXI_PROT_INSN_BIT]};

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;

    // The write owns the RAM port during W_COMMIT; a pending read waits a cycle.
    assign commit   = w_state == W_COMMIT;
    assign rd_go    = r_state == R_READ && !commit;
    assign ram_addr = commit ? w_idx : r_idx;

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:   w_next = aw_hs && w_hs ? W_COMMIT : aw_hs ? W_GOT_AW : w_hs ? W_GOT_W : W_IDLE;
            W_GOT_AW: w_next = w_hs ? W_COMMIT : W_GOT_AW;
            W_GOT_W:  w_next = aw_hs ? W_COMMIT : W_GOT_W;
            W_COMMIT: w_next = W_RESP;
            W_RESP:   w_next = s_axi_bready ? W_IDLE : W_RESP;
            default:  w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  r_next = ar_hs ? R_READ : R_IDLE;
            R_READ:  r_next = rd_go ? R_DATA : R_READ;
            R_DATA:  r_next = s_axi_rready ? R_IDLE : R_DATA;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state       <= W_IDLE;
            r_state       <= R_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_arready <= 1'b0;
            w_resp        <= AXI_RESP_OKAY;
        end else begin
            w_state       <= w_next;
            r_state       <= r_next;
            s_axi_awready <= w_next == W_IDLE || w_next == W_GOT_W;
            s_axi_wready  <= w_next == W_IDLE || w_next == W_GOT_AW;
            s_axi_arready <= r_next == R_IDLE;
            if (commit) w_resp <= axi_resp(w_err);
        end
    end

    always_ff @(posedge aclk) begin
        if (aw_hs) begin
            w_idx <= aw_off[IDX_W+1:2];
            w_err <= aw_err;
        end
        if (w_hs) begin
            w_data <= s_axi_wdata;
            w_strb <= s_axi_wstrb;
        end
        if (ar_hs) begin
            r_idx <= ar_off[IDX_W+1:2];
            r_err <= ar_err;
        end
    end

    assign s_axi_bvalid = w_state == W_RESP;
    assign s_axi_bresp  = s_axi_bvalid ? w_resp : AXI_RESP_OKAY;
    assign s_axi_rvalid = r_state == R_DATA;
    assign s_axi_rresp  = s_axi_rvalid ? axi_resp(r_err) : AXI_RESP_OKAY;
    assign s_axi_rdata  = s_axi_rvalid && !r_err ? ram_q : '0;

    axilite_ram_sp #(.DEPTH(DEPTH)) u_ram (
        .clk   (aclk),
        .we    (commit && !w_err),
        .re    (rd_go),
        .addr  (ram_addr),
        .be    (w_strb),
        .wdata (w_data),
        .rdata (ram_q)
    );
endmodule

// File: tb/tb_axilite_ram_slave.sv
// tb_axilite_ram_slave: directed AXI4-Lite traffic with a B/R response scoreboard.
module tb_axilite_ram_slave;
    import axi_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_2000;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] TOP   = BASE + 32'(DEPTH * 4);

    typedef struct packed {logic [31:0] data; logic [1:0] resp;} r_exp_t;

    logic        aclk = 1'b0, areset = 1'b1;
    logic [31:0] s_axi_awaddr = '0, s_axi_wdata = '0, s_axi_araddr = '0, s_axi_rdata;
    logic [2:0]  s_axi_awprot = '0, s_axi_arprot = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_arvalid = 1'b0;
    logic        s_axi_bready = 1'b1, s_axi_rready = 1'b1;
    logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [1:0]  s_axi_bresp, s_axi_rresp;

    int         tests = 0, failed = 0, b_beats = 0, r_beats = 0, bb, rb;
    logic [1:0] exp_b[$];
    r_exp_t     exp_r[$];
    logic [1:0] mon_b;
    r_exp_t     mon_r;

    always #5 aclk = ~aclk;

    axilite_ram_slave #(.DEPTH(DEPTH), .BASE(BASE), .NS_ONLY(1'b1)) dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every B/R handshake is matched against the oldest expected response.
    always @(negedge aclk) begin
        if (s_axi_bvalid && s_axi_bready) begin
            b_beats++;
            if (exp_b.size() == 0) begin
                tests++; failed++;
                $display("FAIL b_unexpected: got bresp %0d, expected no beat", s_axi_bresp);
            end else begin
                mon_b = exp_b.pop_front();
                chk("bresp", 32'(s_axi_bresp), 32'(mon_b));
            end
        end
        if (s_axi_rvalid && s_axi_rready) begin
            r_beats++;
            if (exp_r.size() == 0) begin
                tests++; failed++;
                $display("FAIL r_unexpected: got rdata 0x%08h, expected no beat", s_axi_rdata);
            end else begin
                mon_r = exp_r.pop_front();
                chk("rresp", 32'(s_axi_rresp), 32'(mon_r.resp));
                chk("rdata", s_axi_rdata, mon_r.data);
            end
        end
    end

    task automatic chk_quiet(input string tag);
        chk({tag, "_awready"}, 32'(s_axi_awready), 0);
        chk({tag, "_wready"},  32'(s_axi_wready),  0);
        chk({tag, "_arready"}, 32'(s_axi_arready), 0);
        chk({tag, "_bvalid"},  32'(s_axi_bvalid),  0);
        chk({tag, "_rvalid"},  32'(s_axi_rvalid),  0);
        chk({tag, "_bresp"},   32'(s_axi_bresp),   0);
        chk({tag, "_rresp"},   32'(s_axi_rresp),   0);
        chk({tag, "_rdata"},   s_axi_rdata,        0);
    endtask

    task automatic hs_aw(input logic [31:0] a, input logic [2:0] p);
        int n = 0;
        s_axi_awaddr = a; s_axi_awprot = p; s_axi_awvalid = 1'b1;
        while (!s_axi_awready && n < 20) begin @(posedge aclk); #1; n++; end
        chk("awready", 32'(s_axi_awready), 1);
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic hs_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
        while (!s_axi_wready && n < 20) begin @(posedge aclk); #1; n++; end
        chk("wready", 32'(s_axi_wready), 1);
        @(posedge aclk); #1;
        s_axi_wvalid = 1'b0;
    endtask

    task automatic hs_ar(input logic [31:0] a, input logic [2:0] p);
        int n = 0;
        s_axi_araddr = a; s_axi_arprot = p; s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < 20) begin @(posedge aclk); #1; n++; end
        chk("arready", 32'(s_axi_arready), 1);
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    // gap > 0: W handshakes first, AW follows gap cycles later.
    task automatic wr_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [2:0] p, input logic [1:0] resp, input int gap);
        exp_b.push_back(resp);
        if (gap == 0) begin
            fork
                hs_aw(a, p);
                hs_w(d, s);
            join
        end else begin
            hs_w(d, s);
            repeat (gap - 1) @(posedge aclk);
            #1;
            hs_aw(a, p);
        end
    endtask

    task automatic rd_req(input logic [31:0] a, input logic [2:0] p,
                          input logic [31:0] d, input logic [1:0] resp);
        exp_r.push_back({d, resp});
        hs_ar(a, p);
    endtask

    // lat counts edges after the handshake edge until valid is seen.
    task automatic wait_b(input int lat);
        int n = 0;
        while (!s_axi_bvalid && n < 20) begin @(posedge aclk); #1; n++; end
        chk("b_latency", 32'(n), 32'(lat));
        if (s_axi_bready) begin @(posedge aclk); #1; end
    endtask

    task automatic wait_r(input int lat);
        int n = 0;
        while (!s_axi_rvalid && n < 20) begin @(posedge aclk); #1; n++; end
        chk("r_latency", 32'(n), 32'(lat));
        if (s_axi_rready) begin @(posedge aclk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        chk_quiet("reset");
        areset = 1'b0;
        @(posedge aclk); #1;
        chk("post_rst_awready", 32'(s_axi_awready), 1);
        chk("post_rst_wready",  32'(s_axi_wready),  1);
        chk("post_rst_arready", 32'(s_axi_arready), 1);

        // 1: AW and W together, then read back
        wr_req(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 3'b010, AXI_RESP_OKAY, 0); wait_b(1);
        rd_req(BASE + 32'h10, 3'b010, 32'hDEADBEEF, AXI_RESP_OKAY); wait_r(1);

        // 2: W three cycles ahead of AW, single byte lane; addr[1:0] ignored on read
        wr_req(BASE + 32'h10, 32'h0000AB00, 4'b0010, 3'b010, AXI_RESP_OKAY, 3); wait_b(1);
        rd_req(BASE + 32'h12, 3'b010, 32'hDEADABEF, AXI_RESP_OKAY); wait_r(1);

        // 3: out of range above and below, word 0 untouched
        wr_req(BASE, 32'hCAFEF00D, 4'hF, 3'b010, AXI_RESP_OKAY, 0); wait_b(1);
        rd_req(TOP, 3'b010, 32'h0, AXI_RESP_SLVERR); wait_r(1);
        rd_req(BASE - 32'h4, 3'b010, 32'h0, AXI_RESP_SLVERR); wait_r(1);
        wr_req(TOP, 32'h55555555, 4'hF, 3'b010, AXI_RESP_SLVERR, 0); wait_b(1);
        rd_req(BASE, 3'b010, 32'hCAFEF00D, AXI_RESP_OKAY); wait_r(1);

        // 4: secure accesses rejected; insn bit ignored
        wr_req(BASE + 32'h20, 32'h0BADC0DE, 4'hF, 3'b010, AXI_RESP_OKAY, 0); wait_b(1);
        wr_req(BASE + 32'h20, 32'h12345678, 4'hF, 3'b000, AXI_RESP_SLVERR, 0); wait_b(1);
        rd_req(BASE + 32'h20, 3'b110, 32'h0BADC0DE, AXI_RESP_OKAY); wait_r(1);
        rd_req(BASE + 32'h20, 3'b000, 32'h0, AXI_RESP_SLVERR); wait_r(1);

        // 5: commit and read collide on one word; responses held under backpressure
        wr_req(BASE + 32'h40, 32'h11111111, 4'hF, 3'b010, AXI_RESP_OKAY, 0); wait_b(1);
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        fork
            wr_req(BASE + 32'h40, 32'hA5A50F0F, 4'hF, 3'b010, AXI_RESP_OKAY, 0);
            rd_req(BASE + 32'h40, 3'b010, 32'hA5A50F0F, AXI_RESP_OKAY);
        join
        fork
            wait_b(1);
            wait_r(2);
        join
        repeat (5) begin
            @(posedge aclk); #1;
            chk("hold_bvalid", 32'(s_axi_bvalid), 1);
            chk("hold_bresp",  32'(s_axi_bresp),  32'(AXI_RESP_OKAY));
            chk("hold_rvalid", 32'(s_axi_rvalid), 1);
            chk("hold_rdata",  s_axi_rdata,       32'hA5A50F0F);
        end
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        @(posedge aclk); #1;
        chk("drain_bvalid", 32'(s_axi_bvalid), 0);
        chk("drain_rvalid", 32'(s_axi_rvalid), 0);

        // 6: reset with a write in W_GOT_AW and a read in R_DATA
        wr_req(BASE + 32'h80, 32'h77778888, 4'hF, 3'b010, AXI_RESP_OKAY, 0); wait_b(1);
        s_axi_rready = 1'b0;
        hs_ar(BASE + 32'h80, 3'b010);
        wait_r(1);
        hs_aw(BASE + 32'h80, 3'b010);
        bb = b_beats; rb = r_beats;
        areset = 1'b1;
        #1;
        chk_quiet("async_rst");
        s_axi_wdata = 32'hFFFFFFFF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        @(posedge aclk); #1;
        chk_quiet("held_rst");
        s_axi_wvalid = 1'b0; areset = 1'b0; s_axi_rready = 1'b1;
        repeat (3) begin @(posedge aclk); #1; end
        chk("abandon_bvalid", 32'(s_axi_bvalid), 0);
        chk("abandon_rvalid", 32'(s_axi_rvalid), 0);
        chk("abandon_b_beats", 32'(b_beats), 32'(bb));
        chk("abandon_r_beats", 32'(r_beats), 32'(rb));
        rd_req(BASE + 32'h80, 3'b010, 32'h77778888, AXI_RESP_OKAY); wait_r(1);

        repeat (2) @(posedge aclk);
        #1;
        chk("b_outstanding", 32'(exp_b.size()), 0);
        chk("r_outstanding", 32'(exp_r.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
